rand_uniform_nb: RTL and testbench
==================================

# rand_uniform_nb

Parametrised uniform pseudo-random word generator: P_WIDTH independent 23-bit LFSR lanes each contribute one bit per output word. Compared with the fixed 8-bit generator, it adds runtime reseeding through a lane-by-lane sequencer, a configurable warm-up discard period, zero-lock protection, and a valid/ready output handshake with back-pressure. It feeds test-pattern, dither and randomised-arbitration consumers.

## Interface
- P_WIDTH, 8: output word width and lane count, 1..64
- P_WARMUP, 32: steps discarded after reset or reseed before the first valid word, 0..65535
- P_SEED, 23'd6975996: base seed loaded at reset
- P_SEED_STEP, 23'h2F5A13: per-lane seed offset constant, odd

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- seed  in  23  runtime base seed
- seed_wr  in  1  one-cycle strobe; starts a reseed with `seed`
- ru  out  P_WIDTH  random word
- ru_valid  out  1  `ru` holds an unconsumed word
- ru_ready  in  1  consumer accepts `ru`
- busy  out  1  high in RESEED or WARMUP

## Operation
- Lane seed: seed_i = base ^ ((i*P_SEED_STEP) mod 2^23). If seed_i is 0, load 23'h000001 instead.
- Lane step: fb = s[22]^s[17]; s <= {s[21:0], fb}. When `ru` loads, ru[i] <= fb of lane i. Lanes step only in WARMUP and on RUN loads.
- Reset:
  - Every lane holds its seed_i from P_SEED.
  - State is WARMUP with cnt=0, or RUN if P_WARMUP=0.
  - ru=0, ru_valid=0, busy=1, or busy=0 if P_WARMUP=0.
- State machine:
  - RESEED:
    - Loads lane idx with the seed accumulator, then increments idx and adds P_SEED_STEP to the accumulator.
    - After lane P_WIDTH-1, go to WARMUP, or to RUN if P_WARMUP=0.
    - Lanes not yet loaded hold their old state.
  - WARMUP:
    - All lanes step every cycle and cnt increments.
    - When cnt reaches P_WARMUP-1, go to RUN.
    - ru_valid stays 0.
  - RUN:
    - When !ru_valid || ru_ready, all lanes step, `ru` loads and ru_valid <= 1.
    - Otherwise lanes and `ru` hold.
- seed_wr in any state has priority:
  - Latch `seed` into the accumulator, idx <= 0, state <= RESEED, ru_valid <= 0.
  - If ru_valid && ru_ready in the same cycle, that word counts as consumed.
  - seed_wr during RESEED or WARMUP restarts from lane 0.
- Reset mid-operation aborts any sequence immediately and applies the reset values above.

## Timing
- Handshake: a transfer occurs on an edge where ru_valid && ru_ready.
  - Under ru_ready=1 a new word issues every cycle; throughput is 1 word/clk.
  - While ru_valid=1 && ru_ready=0, `ru` is stable.
- After the edge that samples seed_wr, the first ru_valid is seen P_WIDTH+P_WARMUP+1 edges later. busy is high for the first P_WIDTH+P_WARMUP of those cycles.
- After reset release, the first ru_valid comes P_WARMUP+1 edges later.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package rand_pkg holds:
  - LFSR_LEN=23 and LFSR_TAP=17
  - the default seed and step constants
  - state enum {RESEED, WARMUP, RUN}
  - a zero-substitution function for lane seeds
- Sub-module lfsr_23_18, instantiated P_WIDTH times via generate:
  - ports clk, rst, load, load_val[22:0], step, fb, state[22:0]
  - parameter P_INIT_SEED
  - load has priority over step and applies zero substitution
- The top holds the FSM, idx, cnt, seed accumulator and output register.

## Test plan
- Fast start: P_WIDTH=1, P_WARMUP=0, ru_ready=1; pulse seed_wr with seed=23'h400000.
  - ru_valid rises 2 edges after the sampling edge.
  - ru[0] sequence starts 1,0,0,...
- Zero-lock: P_WIDTH=1, P_WARMUP=0; reseed with seed=0.
  - Lane loads 23'h000001.
  - The first 17 words are 0 and word 18 is 1; the lane never sticks at 0.
- Default run: P_WIDTH=8, P_WARMUP=32 after reset, ru_ready=1.
  - ru_valid rises at edge 33.
  - Words match a reference model of the 8 lanes seeded P_SEED ^ (i*P_SEED_STEP).
  - busy is 1 for exactly 32 cycles.
- Back-pressure: hold ru_ready=0 for 10 cycles mid-run.
  - `ru` is constant.
  - After release, the next word equals the model's next word; none are skipped or duplicated.
- Reseed collision: assert seed_wr together with ru_valid=1 && ru_ready=1 in RUN.
  - The word counts as transferred and ru_valid=0 next cycle.
  - A second seed_wr during RESEED restarts it; valid returns P_WIDTH+P_WARMUP+1 edges after the last strobe.
- Async reset mid-WARMUP: assert rst between edges.
  - ru_valid=0 and busy=1 immediately.
  - After release, output matches the post-reset sequence.

Source files
------------

// File: rtl/rand_pkg.sv
// rand_pkg: shared constants, state type and seed helpers for the
// rand_uniform_nb generator and its LFSR lanes.
//   LFSR_LEN / LFSR_TAP : lane register length and inner feedback tap
//   DEF_SEED / DEF_SEED_STEP : default base seed and per-lane seed offset
//   state_t  : sequencer states
//   seed_nz  : replaces an all-zero seed with 1 (an all-zero LFSR never moves)
//   lane_seed: seed for lane i = nz(base ^ (i*step mod 2^23))
package rand_pkg;

  localparam int unsigned LFSR_LEN = 23;
  localparam int unsigned LFSR_TAP = 17;

  localparam logic [LFSR_LEN-1:0] DEF_SEED      = 23'd6975996;
  localparam logic [LFSR_LEN-1:0] DEF_SEED_STEP = 23'h2F5A13;

  typedef enum logic [1:0] {
    RESEED = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  function automatic logic [LFSR_LEN-1:0] seed_nz(input logic [LFSR_LEN-1:0] s);
    return (s == '0) ? LFSR_LEN'(1) : s;
  endfunction

  function automatic logic [LFSR_LEN-1:0] lane_seed(
    input logic [LFSR_LEN-1:0] base,
    input logic [LFSR_LEN-1:0] step,
    input int unsigned         lane
  );
    logic [31:0] prod;
    // Only the low 23 bits matter, so 32-bit wraparound is harmless.
    prod = lane * {9'd0, step};
    return seed_nz(base ^ prod[LFSR_LEN-1:0]);
  endfunction

endpackage

// File: rtl/rand_uniform_nb_lfsr_23_18.sv
// lfsr_23_18: one 23-bit Fibonacci LFSR lane (taps 23,18).
//   clk, rst       : clock, asynchronous active-high reset to P_INIT_SEED
//   load, load_val : load a new seed (zero seeds become 1); wins over step
//   step           : shift one position
//   fb             : feedback bit of the current state (the lane's output bit)
//   state          : current register contents
module lfsr_23_18
  import rand_pkg::*;
#(
  parameter logic [LFSR_LEN-1:0] P_INIT_SEED = DEF_SEED
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [LFSR_LEN-1:0] load_val,
  input  logic                step,
  output logic                fb,
  output logic [LFSR_LEN-1:0] state
);

  assign fb = state[LFSR_LEN-1] ^ state[LFSR_TAP];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= seed_nz(P_INIT_SEED);
    end else if (load) begin
      state <= seed_nz(load_val);
    end else if (step) begin
      state <= {state[LFSR_LEN-2:0], fb};
    end
  end

endmodule

// File: rtl/rand_uniform_nb.sv
// rand_uniform_nb: P_WIDTH-bit uniform pseudo-random word generator.
// Each output bit comes from its own 23-bit LFSR lane. Supports runtime
// reseeding (one lane per cycle), a warm-up discard period, and a
// valid/ready output handshake with back-pressure.
//   clk, rst  : clock, asynchronous active-high reset
//   seed      : runtime base seed, sampled when seed_wr is high
//   seed_wr   : one-cycle strobe starting a reseed (priority over everything)
//   ru        : random word
//   ru_valid  : ru holds an unconsumed word
//   ru_ready  : consumer accepts ru (transfer on ru_valid && ru_ready)
//   busy      : high while reseeding or warming up
module rand_uniform_nb
  import rand_pkg::*;
#(
  parameter int unsigned         P_WIDTH     = 8,
  parameter int unsigned         P_WARMUP    = 32,
  parameter logic [LFSR_LEN-1:0] P_SEED      = DEF_SEED,
  parameter logic [LFSR_LEN-1:0] P_SEED_STEP = DEF_SEED_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LFSR_LEN-1:0] seed,
  input  logic                seed_wr,
  output logic [P_WIDTH-1:0]  ru,
  output logic                ru_valid,
  input  logic                ru_ready,
  output logic                busy
);

  localparam logic [6:0]  LAST_IDX = 7'(P_WIDTH - 1);
  localparam logic [15:0] LAST_CNT = 16'(P_WARMUP - 1);

  state_t              state;
  logic [6:0]          idx;
  logic [15:0]         cnt;
  // The seed accumulator is kept as base plus running lane offset, so a
  // reseeded lane i receives base ^ (i*P_SEED_STEP), the same rule used for
  // the reset seeds.
  logic [LFSR_LEN-1:0] base;
  logic [LFSR_LEN-1:0] offset;
  logic [LFSR_LEN-1:0] load_val;

  logic                take;
  logic                step_all;
  logic [P_WIDTH-1:0]  lane_fb;
  logic [P_WIDTH-1:0]  lane_load;
  logic [P_WIDTH-1:0][LFSR_LEN-1:0] lane_state;
  logic                unused_lane_state;

  assign load_val = base ^ offset;
  assign busy     = (state != RUN);

  // Lane state is only observed for debug; fold it so it is not dangling.
  assign unused_lane_state = ^lane_state;

  always_comb begin
    take     = (state == RUN) && (!ru_valid || ru_ready) && !seed_wr;
    step_all = ((state == WARMUP) && !seed_wr) || take;
  end

  for (genvar i = 0; i < P_WIDTH; i++) begin : g_lane
    assign lane_load[i] = (state == RESEED) && !seed_wr && (idx == 7'(i));

    lfsr_23_18 #(
      .P_INIT_SEED(lane_seed(P_SEED, P_SEED_STEP, i))
    ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (lane_load[i]),
      .load_val (load_val),
      .step     (step_all),
      .fb       (lane_fb[i]),
      .state    (lane_state[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (P_WARMUP == 0) state <= RUN;
      else               state <= WARMUP;
      idx      <= '0;
      cnt      <= '0;
      base     <= P_SEED;
      offset   <= '0;
      ru       <= '0;
      ru_valid <= 1'b0;
    end else if (seed_wr) begin
      // A word handed over on this edge is simply dropped from ru_valid;
      // the consumer already took it.
      base     <= seed;
      offset   <= '0;
      idx      <= '0;
      cnt      <= '0;
      state    <= RESEED;
      ru_valid <= 1'b0;
    end else begin
      case (state)
        RESEED: begin
          idx    <= idx + 7'd1;
          offset <= offset + P_SEED_STEP;
          if (idx == LAST_IDX) begin
            cnt <= '0;
            if (P_WARMUP == 0) state <= RUN;
            else               state <= WARMUP;
          end
        end
        WARMUP: begin
          cnt <= cnt + 16'd1;
          if (cnt == LAST_CNT) state <= RUN;
        end
        RUN: begin
          if (take) begin
            ru       <= lane_fb;
            ru_valid <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_uniform_nb.sv
// tb_rand_uniform_nb: randomized self-checking bench for rand_uniform_nb.
// Two instances run side by side: the default 8-lane / 32-step warm-up
// build and a 1-lane / no-warm-up build.
module tb_rand_uniform_nb;

  localparam logic [22:0] SEED_DEF = 23'd6975996;
  localparam logic [22:0] STEP     = 23'h2F5A13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [22:0] seed0, seed1;
  logic        seed_wr0, seed_wr1;
  logic        ready0, ready1;
  logic [7:0]  ru0;
  logic [0:0]  ru1;
  logic        valid0, valid1, busy0, busy1;

  always #5 clk = ~clk;

  rand_uniform_nb #(.P_WIDTH(8), .P_WARMUP(32)) dut (
    .clk(clk), .rst(rst), .seed(seed0), .seed_wr(seed_wr0),
    .ru(ru0), .ru_valid(valid0), .ru_ready(ready0), .busy(busy0)
  );

  rand_uniform_nb #(.P_WIDTH(1), .P_WARMUP(0)) dut1 (
    .clk(clk), .rst(rst), .seed(seed1), .seed_wr(seed_wr1),
    .ru(ru1), .ru_valid(valid1), .ru_ready(ready1), .busy(busy1)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // scoreboard state: current base seed and words consumed since (re)seed
  logic [22:0] base0, base1;
  int unsigned n0, n1;
  logic        hold_pend;
  logic [7:0]  held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word n after (re)seed: lane i starts at base ^ (i*STEP mod 2^23)
  // (zero replaced by 1), runs warm+n shifts, then emits its feedback bit.
  function automatic logic [63:0] model_word(input logic [22:0] base, input int unsigned width,
                                             input int unsigned warm, input int unsigned n);
    logic [63:0] w;
    w = '0;
    for (int unsigned i = 0; i < width; i++) begin
      longint unsigned prod;
      logic [22:0] s;
      prod = longint'(i) * longint'(STEP);
      s = base ^ 23'(prod % 64'h800000);
      if (s == 23'd0) s = 23'd1;
      for (int unsigned k = 0; k < warm + n; k++) s = {s[21:0], s[22] ^ s[17]};
      w[i] = s[22] ^ s[17];
    end
    return w;
  endfunction

  // One clock: score transfers seen before the edge, advance, update model.
  task automatic cycle();
    bit wr0, wr1;
    if (valid0 && ready0) begin
      check("word8", 64'(ru0), model_word(base0, 8, 32, n0));
      n0++;
    end
    if (valid1 && ready1) begin
      check("word1", 64'(ru1), model_word(base1, 1, 0, n1));
      n1++;
    end
    hold_pend = valid0 && !ready0 && !seed_wr0;
    held      = ru0;
    wr0 = seed_wr0;
    wr1 = seed_wr1;
    @(posedge clk);
    #1;
    seed_wr0 = 1'b0;
    seed_wr1 = 1'b0;
    if (wr0) begin base0 = seed0; n0 = 0; end
    if (wr1) begin base1 = seed1; n1 = 0; end
    if (hold_pend) begin
      check("hold_ru", 64'(ru0), 64'(held));
      check("hold_valid", 64'(valid0), 64'd1);
    end
  endtask

  task automatic wait_valid(input bit sel, output int edges);
    edges = 0;
    for (int e = 1; e <= 200; e++) begin
      cycle();
      if (sel ? valid1 : valid0) begin
        edges = e;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, e1, busy_cnt;
    seed0 = '0; seed1 = '0;
    seed_wr0 = 1'b0; seed_wr1 = 1'b0;
    ready0 = 1'b1; ready1 = 1'b1;
    base0 = SEED_DEF; base1 = SEED_DEF;
    n0 = 0; n1 = 0;
    hold_pend = 1'b0; held = '0;

    // reset values
    #12;
    check("rst_ru", 64'(ru0), 64'd0);
    check("rst_valid", 64'(valid0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd1);
    check("rst_ru1", 64'(ru1), 64'd0);
    check("rst_valid1", 64'(valid1), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);

    // default run from reset: latency and busy length
    @(negedge clk);
    rst = 1'b0;
    busy_cnt = 0; e = 0; e1 = 0;
    for (int k = 1; k <= 100; k++) begin
      if (busy0) busy_cnt++;
      cycle();
      if (valid1 && e1 == 0) e1 = k;
      if (valid0) begin e = k; break; end
    end
    check("rst_lat8", 64'(e), 64'd33);
    check("rst_lat1", 64'(e1), 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'd32);
    repeat (40) cycle();

    // back-pressure
    ready0 = 1'b0;
    repeat (10) cycle();
    ready0 = 1'b1;
    repeat (10) cycle();

    // fast start on the 1-lane build
    seed1 = 23'h400000; seed_wr1 = 1'b1;
    cycle();
    wait_valid(1'b1, e);
    check("fast_lat", 64'(e), 64'd2);
    check("fast_w0", 64'(ru1), 64'd1);
    cycle();
    check("fast_w1", 64'(ru1), 64'd0);
    cycle();
    check("fast_w2", 64'(ru1), 64'd0);

    // zero-lock: seed 0 behaves as seed 1
    seed1 = 23'd0; seed_wr1 = 1'b1;
    cycle();
    wait_valid(1'b1, e);
    check("zl_lat", 64'(e), 64'd2);
    for (int k = 0; k < 20; k++) begin
      check("zl_word", 64'(ru1), 64'(k == 17));
      cycle();
    end

    // reseed colliding with a transfer, then a restart during RESEED
    check("coll_pre", 64'(valid0), 64'd1);
    seed0 = 23'($urandom); seed_wr0 = 1'b1;
    cycle();
    check("coll_valid", 64'(valid0), 64'd0);
    check("coll_busy", 64'(busy0), 64'd1);
    repeat (3) cycle();
    seed0 = 23'($urandom); seed_wr0 = 1'b1;
    cycle();
    wait_valid(1'b0, e);
    check("reseed_lat", 64'(e), 64'd41);
    repeat (30) cycle();

    // asynchronous reset in the middle of WARMUP
    seed0 = 23'($urandom); seed_wr0 = 1'b1;
    cycle();
    repeat (18) cycle();
    check("pre_arst_busy", 64'(busy0), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(valid0), 64'd0);
    check("arst_busy", 64'(busy0), 64'd1);
    check("arst_valid1", 64'(valid1), 64'd0);
    check("arst_ru1", 64'(ru1), 64'd0);
    check("arst_busy1", 64'(busy1), 64'd0);
    #2;
    rst = 1'b0;
    base0 = SEED_DEF; base1 = SEED_DEF;
    n0 = 0; n1 = 0;
    wait_valid(1'b0, e);
    check("arst_lat", 64'(e), 64'd33);
    repeat (40) cycle();

    // randomized handshake and reseed traffic
    for (int k = 0; k < 400; k++) begin
      ready0 = 1'($urandom_range(0, 1));
      ready1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 60) == 0) begin
        seed0 = 23'($urandom); seed_wr0 = 1'b1;
      end
      if ($urandom_range(0, 30) == 0) begin
        seed1 = 23'($urandom); seed_wr1 = 1'b1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
